onehot_rr_arbiter: RTL and testbench
====================================

# onehot_rr_arbiter

Round-robin arbiter that shares one resource among 8 requesters and drives a registered one-hot grant vector in the same encoding as the team's 3-to-8 select decoders. Sits in front of shared datapath resources. The one-hot `gnt` bus drives per-requester enables directly, and `gnt_idx` drives the resource's 3-bit select.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; used only when `ARB_HOLD_TIMEOUT_EN` is defined; legal range 2..255.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  8: request per requester; level-sensitive; bit n = requester n.
- `done`  in  1: single-cycle release pulse from the current grant holder.
- `gnt`  out  8: registered one-hot grant; all-zero when no grant.
- `gnt_idx`  out  3: binary index of the granted requester; valid only when `gnt_valid`=1.
- `gnt_valid`  out  1: high while any grant is active; equals |`gnt`.
- `timeout`  out  1: one-cycle pulse on a forced revoke.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit priority pointer `ptr`.
  - 8-bit hold counter, present only with the macro.
- IDLE:
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, …, `ptr`+7, with indices mod 8.
  - Register `gnt` = 1<<idx, `gnt_idx` = idx, `gnt_valid` = 1; go to GRANT.
  - If `req`=0, stay in IDLE with outputs zero.
- GRANT: hold the grant unchanged until one of the following release conditions occurs:
  - (a) `done`=1.
  - (b) `req[gnt_idx]`=0, meaning the requester withdrew.
  - (c) a forced revoke from the timeout, macro builds only.
- On release:
  - Clear `gnt`, `gnt_valid`, and `gnt_idx` to 0.
  - Set `ptr` = `gnt_idx`+1 (wraps 7→0).
  - Go to IDLE.
- Wrap-around: with `ptr`=6 and `req`=8'b0000_0011, requester 0 wins.
- Simultaneous events:
  - `done` and withdrawal in the same cycle count as a single release.
  - `done` together with a timeout is a normal release; `timeout` stays 0.
- Ignored inputs:
  - `done` in IDLE is ignored.
  - Changes to other `req` bits during GRANT are ignored.
- Fairness: a requester that keeps `req` high is granted within 8 grant tenures.
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0.
  - `ptr`=0, FSM=IDLE, hold counter=0.
- Reset mid-grant: outputs clear asynchronously on `rst` assertion without waiting for a clock edge. After deassertion, arbitration restarts with `ptr`=0.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k gives `gnt` valid after edge k, i.e. 1 cycle.
- Release: a condition sampled at edge k clears `gnt` after edge k.
- Re-grant: at the earliest after edge k+1, so there is exactly one idle cycle between tenures. No back-to-back grants.
- Minimum tenure is 1 cycle, as with `done` sampled at the first edge in GRANT.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.
- `gnt`, `gnt_idx` and `gnt_valid` always change on the same edge.

## Configuration
- `ARB_HOLD_TIMEOUT_EN` defined:
  - The hold counter clears on entry to GRANT and increments on each GRANT cycle.
  - When the counter reaches `MAX_HOLD` with no other release condition, the grant is force-revoked at that edge.
  - `timeout` pulses high for exactly that one cycle, aligned with `gnt` clearing.
  - `ptr` advances past the revoked requester.
- `ARB_HOLD_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely until `done` or withdrawal.

## Test plan
- Reset: assert `rst` mid-grant (`gnt`=8'h04). Expect `gnt`=0 and `gnt_valid`=0 before the next edge; after release with `req`=8'hFF, the first `gnt`=8'h01.
- Rotation: `req`=8'hFF held, `done` pulsed in each tenure. Expect grant sequence 8'h01, 8'h02, …, 8'h80, 8'h01, with one zero cycle between consecutive grants.
- Wrap/skip: grant to 5 released; then `req`=8'b0000_1001. Expect `gnt`=8'h01 (`gnt_idx`=0), then after its release `gnt`=8'h08.
- Withdrawal: requester 3 granted, `req[3]` dropped with no `done`. Expect `gnt`=0 on the next edge and `ptr`=4.
- Simultaneous: `done` and `req[gnt_idx]` drop in the same cycle. Expect a single release, one idle cycle, and no spurious `timeout`.
- Timeout (macro defined, `MAX_HOLD`=4): requester 2 holds with no `done`. Expect `gnt`=8'h04 for 4 cycles, then `gnt`=0 with `timeout`=1 for one cycle, and the next grant goes to requester ≥3. With the macro undefined, the same stimulus holds 8'h04 indefinitely and `timeout` stays 0.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: 8-way round-robin arbiter, registered one-hot grant.
// Define ARB_HOLD_TIMEOUT_EN to force-revoke grants held for MAX_HOLD cycles.

module onehot_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       tmo_q, tmo_d;

  logic       pick_ok;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       tmo_hit;
  logic       rel;

  // First requester at or after ptr, wrapping mod 8
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 3'd0;
    cand     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_ok && req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Revoke only when nothing else releases; done wins over timeout
  assign tmo_hit = (cnt_q == 8'(MAX_HOLD - 1)) && !done && req[idx_q];

  always_comb begin
    cnt_d = 8'd0;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign rel = done | ~req[idx_q] | tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    vld_d = vld_q;
    tmo_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 8'd0;
        idx_d = 3'd0;
        vld_d = 1'b0;
        if (pick_ok) begin
          gnt_d = 8'd1 << pick_idx;
          idx_d = pick_idx;
          vld_d = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          gnt_d = 8'd0;
          idx_d = 3'd0;
          vld_d = 1'b0;
          tmo_d = tmo_hit;
        end
      end
      default: begin
        gnt_d = 8'd0;
        idx_d = 3'd0;
        vld_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed tests for the round-robin arbiter.
// Works with or without ARB_HOLD_TIMEOUT_EN (MAX_HOLD fixed at 4).

module tb_onehot_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  onehot_rr_arbiter #(
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 ||
        gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals gnt=%h idx=%0d vld=%b tmo=%b exp 00/0/0/0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    rst = 1'b0;
    req = 8'h04;
    tick();
    checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_gnt gnt=%h idx=%0d vld=%b exp 04/2/1",
               gnt, gnt_idx, gnt_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset gnt=%h vld=%b exp 00/0", gnt, gnt_valid);
    end
    rst = 1'b0;
    req = 8'hFF;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_gnt gnt=%h idx=%0d exp 01/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp8;
    for (int k = 1; k <= 8; k++) begin
      done = 1'b1;
      tick();
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rot_idle k=%0d gnt=%h vld=%b exp 00/0",
                 k, gnt, gnt_valid);
      end
      done = 1'b0;
      tick();
      exp8 = 8'h01 << (k % 8);
      checks++;
      if (gnt !== exp8 || gnt_idx !== 3'(k % 8) || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rot_gnt k=%0d gnt=%h idx=%0d exp %h/%0d",
                 k, gnt, gnt_idx, exp8, k % 8);
      end
    end
  endtask

  task automatic test_wrap_skip();
    req = 8'h20;
    tick();
    checks++;
    if (gnt !== 8'h00) begin
      errors++;
      $display("FAIL wrap_drop0 gnt=%h exp 00", gnt);
    end
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL wrap_gnt5 gnt=%h idx=%0d exp 20/5", gnt, gnt_idx);
    end
    done = 1'b1;
    req  = 8'b0000_1001;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_gnt0 gnt=%h idx=%0d exp 01/0", gnt, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL skip_gnt3 gnt=%h idx=%0d exp 08/3", gnt, gnt_idx);
    end
  endtask

  task automatic test_withdrawal();
    req = 8'h01;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL withdraw gnt=%h vld=%b tmo=%b exp 00/0/0",
               gnt, gnt_valid, timeout);
    end
    req = 8'h11;
    tick();
    checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      errors++;
      $display("FAIL withdraw_ptr gnt=%h idx=%0d exp 10/4", gnt, gnt_idx);
    end
  endtask

  task automatic test_simultaneous();
    done = 1'b1;
    req  = 8'h01;
    tick();
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL simul_rel gnt=%h tmo=%b exp 00/0", gnt, timeout);
    end
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL simul_next gnt=%h idx=%0d tmo=%b exp 01/0/0",
               gnt, gnt_idx, timeout);
    end
    done = 1'b1;
    tick();
    req = 8'h04;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL idle_done gnt=%h idx=%0d exp 04/2", gnt, gnt_idx);
    end
  endtask

  task automatic test_timeout();
    req = 8'h0C;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h04 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold c=%0d gnt=%h tmo=%b exp 04/0",
                 c, gnt, timeout);
      end
    end
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_revoke gnt=%h vld=%b tmo=%b exp 00/0/1",
               gnt, gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_next gnt=%h idx=%0d tmo=%b exp 08/3/0",
               gnt, gnt_idx, timeout);
    end
`else
    for (int c = 2; c <= 20; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h04 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL hold_forever c=%0d gnt=%h tmo=%b exp 04/0",
                 c, gnt, timeout);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold_release gnt=%h tmo=%b exp 00/0", gnt, timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL hold_next gnt=%h idx=%0d exp 08/3", gnt, gnt_idx);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_withdrawal();
    test_simultaneous();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
